robertson_useq: RTL and testbench

//  Microsequencer for the Robertson signed (two's-complement) multiplier datapath.

---
 rtl/robertson_useq_if.sv | 26 ++
 rtl/robertson_useq.sv | 89 ++++++++
 tb/tb_robertson_useq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/robertson_useq_if.sv
// Host/datapath-facing signal bundle for the Robertson multiplier microsequencer.
interface robertson_useq_if;
  logic       start;
  logic       abort;
  logic       q0;
  logic       load_xy;
  logic       clr_a;
  logic       add_en;
  logic       sub_en;
  logic       shift_en;
  logic       busy;
  logic       done;
  logic [4:0] upc;

  // Host and datapath side: drives requests and Q[0], observes strobes.
  modport master (
    output start, abort, q0,
    input  load_xy, clr_a, add_en, sub_en, shift_en, busy, done, upc
  );

  // Sequencer side.
  modport slave (
    input  start, abort, q0,
    output load_xy, clr_a, add_en, sub_en, shift_en, busy, done, upc
  );
endinterface

// File: rtl/robertson_useq.sv
// Microsequencer for a Robertson signed multiplier: 5-bit micro-PC plus
// iteration counter, Moore-decoded into A/Q/X datapath strobes.
module robertson_useq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  robertson_useq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [4:0] {
    UPC_IDLE   = 5'd0,
    UPC_INIT   = 5'd1,
    UPC_TEST   = 5'd2,
    UPC_ADD    = 5'd3,
    UPC_SHIFT  = 5'd4,
    UPC_LTEST  = 5'd5,
    UPC_SUB    = 5'd6,
    UPC_LSHIFT = 5'd7,
    UPC_DONE   = 5'd8
  } upc_e;

  upc_e             upc_q, upc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Micro-PC and iteration counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc_q <= UPC_IDLE;
      cnt_q <= '0;
    end else begin
      upc_q <= upc_d;
      cnt_q <= cnt_d;
    end
  end

  // Next micro-address and counter update; abort overrides every branch.
  always_comb begin
    upc_d = UPC_IDLE;
    cnt_d = cnt_q;
    case (upc_q)
      UPC_IDLE:   upc_d = bus.start ? UPC_INIT : UPC_IDLE;
      UPC_INIT: begin
        upc_d = UPC_TEST;
        cnt_d = CNT_W'(WIDTH - 1);
      end
      UPC_TEST:   upc_d = bus.q0 ? UPC_ADD : UPC_SHIFT;
      UPC_ADD:    upc_d = UPC_SHIFT;
      UPC_SHIFT: begin
        // Compare uses the count before this shift's decrement.
        upc_d = (cnt_q == CNT_W'(1)) ? UPC_LTEST : UPC_TEST;
        cnt_d = cnt_q - CNT_W'(1);
      end
      UPC_LTEST:  upc_d = bus.q0 ? UPC_SUB : UPC_LSHIFT;
      UPC_SUB:    upc_d = UPC_LSHIFT;
      UPC_LSHIFT: upc_d = UPC_DONE;
      UPC_DONE:   upc_d = UPC_IDLE;
      default:    upc_d = UPC_IDLE;
    endcase
    if (bus.abort) upc_d = UPC_IDLE;
  end

  // Moore decode of the micro-word into datapath strobes and status.
  always_comb begin
    bus.load_xy  = 1'b0;
    bus.clr_a    = 1'b0;
    bus.add_en   = 1'b0;
    bus.sub_en   = 1'b0;
    bus.shift_en = 1'b0;
    bus.done     = 1'b0;
    bus.busy     = (upc_q != UPC_IDLE);
    bus.upc      = upc_q;
    case (upc_q)
      UPC_INIT: begin
        bus.load_xy = 1'b1;
        bus.clr_a   = 1'b1;
      end
      UPC_ADD:    bus.add_en   = 1'b1;
      UPC_SHIFT:  bus.shift_en = 1'b1;
      UPC_SUB:    bus.sub_en   = 1'b1;
      UPC_LSHIFT: bus.shift_en = 1'b1;
      UPC_DONE:   bus.done     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_robertson_useq.sv
// Bench for robertson_useq: drives a behavioural A/Q/X datapath from the
// strobes and checks latency, strobe counts and the signed product.
module tb_robertson_useq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  robertson_useq_if bus();

  robertson_useq #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int           A;
  int           X;
  logic [W-1:0] Q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.load_xy, bus.clr_a, bus.add_en, bus.sub_en, bus.shift_en, bus.done, bus.busy};
  endfunction

  // Applies this cycle's strobes to the datapath, then presents Q[0].
  // qmode: 0 = datapath Q[0], 1 = q0 forced 0, 2 = q0 forced 1.
  task automatic model_step(input logic [W-1:0] x, input logic [W-1:0] y, input int qmode);
    if (bus.load_xy) begin
      X = int'($signed(x));
      Q = y;
    end
    if (bus.clr_a)    A = 0;
    if (bus.add_en)   A = A + X;
    if (bus.sub_en)   A = A - X;
    if (bus.shift_en) begin
      Q = {A[0], Q[W-1:1]};
      A = A >>> 1;
    end
    bus.q0 = (qmode == 0) ? Q[0] : (qmode == 2);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int qmode, input bit chk_prod, input bit hold_start);
    logic [W-1:0] ye;
    int k, exp_done, adds, subs, shifts, done_cyc, cyc, multi, prod, exp_prod;
    ye = (qmode == 0) ? y : ((qmode == 1) ? '0 : '1);
    k = 0;
    for (int i = 0; i < W - 1; i++) k += int'(ye[i]);
    exp_done = 2 + 2 * (W - 1) + k + 2 + int'(ye[W-1]);
    adds = 0; subs = 0; shifts = 0; multi = 0; done_cyc = -1;

    @(negedge clk);
    bus.q0    = (qmode == 2);
    bus.start = 1'b1;
    cyc = 0;
    while (done_cyc < 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!hold_start) bus.start = (cyc == 5);  // pulse while busy: must be ignored
      if (cyc == 1) check({tag, "_init_upc"}, 32'(bus.upc), 32'd1);
      adds   += int'(bus.add_en);
      subs   += int'(bus.sub_en);
      shifts += int'(bus.shift_en);
      if (int'(bus.load_xy) + int'(bus.add_en) + int'(bus.sub_en) + int'(bus.shift_en) > 1)
        multi++;
      if (bus.done) done_cyc = cyc;
      model_step(x, y, qmode);
    end
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
    check({tag, "_adds"},     32'(adds),     32'(k));
    check({tag, "_subs"},     32'(subs),     32'(ye[W-1]));
    check({tag, "_shifts"},   32'(shifts),   32'(W));
    check({tag, "_onehot"},   32'(multi),    32'd0);
    if (chk_prod) begin
      prod     = A * 256 + int'(Q);
      exp_prod = int'($signed(x)) * int'($signed(y));
      check({tag, "_product"}, 32'(prod), 32'(exp_prod));
    end

    @(negedge clk);
    check({tag, "_after_upc"}, 32'(bus.upc), 32'd0);
    if (hold_start) begin
      @(negedge clk);
      check({tag, "_restart_upc"}, 32'(bus.upc), 32'd1);
      bus.start = 1'b0;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
    end else begin
      check({tag, "_after_busy"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      check({tag, "_no_queue_upc"}, 32'(bus.upc), 32'd0);
    end
  endtask

  task automatic abort_test();
    int dones;
    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      model_step(8'd5, 8'hA5, 0);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_upc",  32'(bus.upc), 32'd0);
    check("abort_outs", 32'(outs()), 32'd0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      dones += int'(bus.done);
    end
    check("abort_no_done", 32'(dones), 32'd0);
    // abort beats start in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    check("abort_idle_upc", 32'(bus.upc), 32'd0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic reset_test();
    @(negedge clk);
    bus.q0    = 1'b0;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("rst_pre_upc",   32'(bus.upc), 32'd4);
    check("rst_pre_shift", 32'(bus.shift_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_upc",   32'(bus.upc), 32'd0);
    check("rst_async_shift", 32'(bus.shift_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_post_outs", 32'(outs()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] rx, ry;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.q0    = 1'b0;
    A = 0; X = 0; Q = '0;

    repeat (3) @(negedge clk);
    check("reset_outs", 32'(outs()), 32'd0);
    check("reset_upc",  32'(bus.upc), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_outs", 32'(outs()), 32'd0);
    check("idle_upc",  32'(bus.upc), 32'd0);

    run_op("q0_zero", 8'd7, 8'd0, 1, 1'b0, 1'b0);
    run_op("q0_one",  8'd7, 8'd0, 2, 1'b0, 1'b0);
    run_op("y_m3",    8'd9, 8'hFD, 0, 1'b1, 1'b0);
    run_op("hold",    8'd3, 8'd0, 1, 1'b0, 1'b1);
    run_op("min_min", 8'h80, 8'h80, 0, 1'b1, 1'b0);
    run_op("min_max", 8'h80, 8'h7F, 0, 1'b1, 1'b0);
    run_op("one_neg", 8'h01, 8'hFF, 0, 1'b1, 1'b0);

    abort_test();
    run_op("post_abort", 8'd11, 8'd13, 0, 1'b1, 1'b0);

    reset_test();
    run_op("post_reset", 8'hF3, 8'h21, 0, 1'b1, 1'b0);

    for (int n = 0; n < 20; n++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      run_op("rand", rx, ry, 0, 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
